// File: rtl/pic_int_ctrl.sv
// Programmable interrupt controller: mask, edge/level capture, fixed priority,
// intr/inta handshake with the CPU and a small word-addressed register port.
module pic_int_ctrl #(
  parameter int NSRC = 8,
  parameter int IDW  = 5
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [NSRC-1:0] src,
  output logic            intr,
  input  logic            inta,
  input  logic [2:0]      addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [NSRC-1:0] low1(input logic [NSRC-1:0] v);
    return v & (~v + NSRC'(1'b1));
  endfunction

  function automatic logic [IDW-1:0] low_idx(input logic [NSRC-1:0] v);
    logic [IDW-1:0] idx;
    idx = {IDW{1'b0}};
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
  logic [NSRC-1:0] isr_q, isr_d, src_prev_q;
  logic            spur_q, spur_d, intr_q, intr_d;
  state_t          state_q, state_d;

  logic [NSRC-1:0] wbits, rise, pend_eff, cand, win1, set_b, clr_b, swi_b, w1c_b;
  logic [NSRC-1:0] isr_eoi, fsm_pend, fsm_cand;
  logic            ack, eligible;
  logic            wr_pend, wr_mask, wr_mode, wr_vec, wr_eoi, wr_swi;

  assign wbits = NSRC'(wdata);
  assign intr  = intr_q;

  // Next-state computation for pending, mask, mode, ISR, spurious flag and FSM.
  always_comb begin
    wr_pend  = we && (addr == 3'd0);
    wr_mask  = we && (addr == 3'd1);
    wr_mode  = we && (addr == 3'd2);
    wr_vec   = we && (addr == 3'd4);
    wr_eoi   = we && (addr == 3'd5);
    wr_swi   = we && (addr == 3'd6);
    swi_b    = wr_swi ? wbits : {NSRC{1'b0}};
    w1c_b    = wr_pend ? wbits : {NSRC{1'b0}};
    rise     = src & ~src_prev_q;
    pend_eff = (pend_q & mode_q) | (src & ~mode_q);
    cand     = pend_eff & mask_q;
    win1     = low1(cand);
    ack      = (state_q == REQ) && inta && (cand != {NSRC{1'b0}});

    set_b  = (rise | swi_b) & mode_q;
    clr_b  = (w1c_b | (ack ? win1 : {NSRC{1'b0}})) & mode_q;
    pend_d = ((pend_q & ~clr_b) | set_b) & mode_q;
    mask_d = wr_mask ? wbits : mask_q;
    mode_d = wr_mode ? wbits : mode_q;

    // EOI retires the current level before an acknowledge adds a new one.
    isr_eoi = wr_eoi ? (isr_q & ~low1(isr_q)) : isr_q;
    isr_d   = ack ? (isr_eoi | win1) : isr_eoi;

    if (inta && !ack) begin
      spur_d = 1'b1;
    end else if (wr_vec && wdata[30]) begin
      spur_d = 1'b0;
    end else begin
      spur_d = spur_q;
    end

    // The FSM sees software effects this cycle; fresh src edges wait for capture.
    fsm_pend = (((pend_q & ~clr_b) | (pend_q & rise) | swi_b) & mode_q) | (src & ~mode_q);
    fsm_cand = fsm_pend & mask_d;
    eligible = (fsm_cand != {NSRC{1'b0}}) &&
               ((isr_d == {NSRC{1'b0}}) || (low1(fsm_cand) < low1(isr_d)));

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (eligible) state_d = REQ;
        else          state_d = IDLE;
      end
      REQ: begin
        if (ack)            state_d = HOLD;
        else if (!eligible) state_d = IDLE;
        else                state_d = REQ;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    intr_d = (state_d == REQ);
  end

  // State registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pend_q     <= {NSRC{1'b0}};
      mask_q     <= {NSRC{1'b0}};
      mode_q     <= {NSRC{1'b0}};
      isr_q      <= {NSRC{1'b0}};
      src_prev_q <= {NSRC{1'b0}};
      spur_q     <= 1'b0;
      intr_q     <= 1'b0;
      state_q    <= IDLE;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      isr_q      <= isr_d;
      src_prev_q <= src;
      spur_q     <= spur_d;
      intr_q     <= intr_d;
      state_q    <= state_d;
    end
  end

  // Register read mux.
  always_comb begin
    case (addr)
      3'd0:    rdata = 32'(pend_eff);
      3'd1:    rdata = 32'(mask_q);
      3'd2:    rdata = 32'(mode_q);
      3'd3:    rdata = 32'(isr_q);
      3'd4:    rdata = {(isr_q != {NSRC{1'b0}}), spur_q, 30'(low_idx(isr_q))};
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_pic_int_ctrl.sv
// Scoreboard bench for pic_int_ctrl: directed test-plan sequences then random
// traffic, checked against a behavioural model of the controller's rules.
module tb_pic_int_ctrl;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic [N-1:0]  src = '0;
  logic          intr;
  logic          inta = 1'b0;
  logic [2:0]    addr = 3'd0;
  logic          we = 1'b0;
  logic [31:0]   wdata = 32'd0;
  logic [31:0]   rdata;

  pic_int_ctrl #(.NSRC(N), .IDW(5)) dut (
    .clk(clk), .clrn(clrn), .src(src), .intr(intr), .inta(inta),
    .addr(addr), .we(we), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        intr;
    logic [31:0] rd;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state (0 idle, 1 requesting, 2 holdoff).
  logic [N-1:0] m_pend, m_mask, m_mode, m_isr, m_prev;
  logic         m_spur, m_intr;
  int           m_st;

  logic         ov_en = 1'b0;
  logic [31:0]  ov_rd;
  logic         ov_intr;

  function automatic int first1(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return N;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = '0; m_isr = '0; m_prev = '0;
    m_spur = 1'b0; m_intr = 1'b0; m_st = 0;
  endtask

  task automatic model_step(input logic [N-1:0] s, input logic ia, input logic w,
                            input logic [2:0] a, input logic [31:0] d);
    logic [N-1:0] now, fview, npend, nisr, nmask;
    int win, f, il;
    logic ack, elig, rise, swi, clr;
    if (!clrn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) now[i] = m_mode[i] ? m_pend[i] : s[i];
    win = first1(now & m_mask);
    ack = (m_st == 1) && ia && (win < N);
    nmask = (w && a == 3'd1) ? d[N-1:0] : m_mask;
    for (int i = 0; i < N; i++) begin
      rise = s[i] && !m_prev[i];
      swi  = w && (a == 3'd6) && d[i];
      clr  = (w && (a == 3'd0) && d[i]) || (ack && i == win);
      if (m_mode[i]) begin
        npend[i] = (rise || swi) ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
        fview[i] = swi || (m_pend[i] && (!clr || rise));
      end else begin
        npend[i] = 1'b0;
        fview[i] = s[i];
      end
    end
    nisr = m_isr;
    if (w && a == 3'd5 && first1(nisr) < N) nisr[first1(nisr)] = 1'b0;
    if (ack) nisr[win] = 1'b1;
    f  = first1(fview & nmask);
    il = first1(nisr);
    elig = (f < N) && (f < il);
    if (ia && !ack) m_spur = 1'b1;
    else if (w && a == 3'd4 && d[30]) m_spur = 1'b0;
    case (m_st)
      0:       m_st = elig ? 1 : 0;
      1:       m_st = ack ? 2 : (elig ? 1 : 0);
      default: m_st = 0;
    endcase
    m_intr = (m_st == 1);
    m_pend = npend;
    m_mask = nmask;
    if (w && a == 3'd2) m_mode = d[N-1:0];
    m_isr  = nisr;
    m_prev = s;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a, input logic [N-1:0] s);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0: r[N-1:0] = (m_pend & m_mode) | (s & ~m_mode);
      3'd1: r[N-1:0] = m_mask;
      3'd2: r[N-1:0] = m_mode;
      3'd3: r[N-1:0] = m_isr;
      3'd4: begin
        r[31] = (m_isr != '0);
        r[30] = m_spur;
        if (m_isr != '0) r[4:0] = 5'(first1(m_isr));
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic expect_c(input logic [31:0] rd, input logic ir);
    ov_en = 1'b1; ov_rd = rd; ov_intr = ir;
  endtask

  task automatic drive(input logic [N-1:0] s, input logic ia, input logic w,
                       input logic [2:0] a, input logic [31:0] d, input string nm);
    exp_t e;
    src = s; inta = ia; we = w; addr = a; wdata = d;
    model_step(s, ia, w, a, d);
    e.intr = m_intr;
    e.rd   = model_read(a, s);
    e.nm   = nm;
    if (ov_en) begin
      e.rd = ov_rd; e.intr = ov_intr; ov_en = 1'b0;
    end
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (intr !== e.intr || rdata !== e.rd) begin
        n_fail++;
        $display("FAIL %s: got intr=%0b rdata=%08h, want intr=%0b rdata=%08h",
                 e.nm, intr, rdata, e.intr, e.rd);
      end
    end
  end

  task automatic direct_chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", nm, act, want);
    end
  endtask

  initial begin
    logic [N-1:0] s;
    logic ia, w;
    logic [2:0] a;
    logic [31:0] d;
    model_reset();
    @(negedge clk); #1;
    expect_c(32'h0, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd1, 32'h0, "rst_mask");
    expect_c(32'h0, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd4, 32'h0, "rst_vec");
    clrn = 1'b1;
    // Edge source 0: capture, request, acknowledge.
    expect_c(32'h1, 1'b0); drive(8'h00, 1'b0, 1'b1, 3'd1, 32'h1, "t1_mask");
    expect_c(32'h1, 1'b0); drive(8'h00, 1'b0, 1'b1, 3'd2, 32'h1, "t1_mode");
    expect_c(32'h1, 1'b0); drive(8'h01, 1'b0, 1'b0, 3'd0, 32'h0, "t1_pend");
    expect_c(32'h1, 1'b1); drive(8'h00, 1'b0, 1'b0, 3'd0, 32'h0, "t1_intr");
    expect_c(32'h1, 1'b0); drive(8'h00, 1'b1, 1'b0, 3'd3, 32'h0, "t1_ack_isr");
    expect_c(32'h0, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd0, 32'h0, "t1_pend0");
    expect_c(32'h8000_0000, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd4, 32'h0, "t1_vec");
    drive(8'h00, 1'b0, 1'b1, 3'd5, 32'h0, "t1_eoi");
    expect_c(32'h0, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd3, 32'h0, "t1_isr0");
    // Two simultaneous edges: priority, EOI, second acknowledge.
    drive(8'h00, 1'b0, 1'b1, 3'd1, 32'h0C, "t2_mask");
    drive(8'h00, 1'b0, 1'b1, 3'd2, 32'h0C, "t2_mode");
    expect_c(32'h0C, 1'b0); drive(8'h0C, 1'b0, 1'b0, 3'd0, 32'h0, "t2_pend");
    expect_c(32'h0C, 1'b1); drive(8'h0C, 1'b0, 1'b0, 3'd0, 32'h0, "t2_intr");
    expect_c(32'h04, 1'b0); drive(8'h0C, 1'b1, 1'b0, 3'd3, 32'h0, "t2_ack_isr");
    expect_c(32'h8000_0002, 1'b0); drive(8'h0C, 1'b0, 1'b0, 3'd4, 32'h0, "t2_vec");
    expect_c(32'h08, 1'b0); drive(8'h0C, 1'b0, 1'b0, 3'd0, 32'h0, "t2_pend3");
    expect_c(32'h0, 1'b1); drive(8'h0C, 1'b0, 1'b1, 3'd5, 32'h0, "t2_eoi_intr");
    expect_c(32'h08, 1'b0); drive(8'h0C, 1'b1, 1'b0, 3'd3, 32'h0, "t2_ack2_isr");
    // Nesting: source 1 preempts in-service source 3.
    drive(8'h0C, 1'b0, 1'b1, 3'd2, 32'h0E, "t3_mode");
    drive(8'h0C, 1'b0, 1'b1, 3'd1, 32'h0A, "t3_mask");
    expect_c(32'h02, 1'b0); drive(8'h0E, 1'b0, 1'b0, 3'd0, 32'h0, "t3_pend");
    expect_c(32'h02, 1'b1); drive(8'h0E, 1'b0, 1'b0, 3'd0, 32'h0, "t3_intr");
    expect_c(32'h0A, 1'b0); drive(8'h0E, 1'b1, 1'b0, 3'd3, 32'h0, "t3_ack_isr");
    expect_c(32'h8000_0001, 1'b0); drive(8'h0E, 1'b0, 1'b0, 3'd4, 32'h0, "t3_vec");
    drive(8'h0E, 1'b0, 1'b1, 3'd5, 32'h0, "t3_eoi1");
    expect_c(32'h08, 1'b0); drive(8'h0E, 1'b0, 1'b0, 3'd3, 32'h0, "t3_isr8");
    drive(8'h0E, 1'b0, 1'b1, 3'd5, 32'h0, "t3_eoi2");
    expect_c(32'h0, 1'b0); drive(8'h0E, 1'b0, 1'b0, 3'd3, 32'h0, "t3_isr0");
    // Level source 4.
    drive(8'h00, 1'b0, 1'b1, 3'd1, 32'h10, "t4_mask");
    drive(8'h00, 1'b0, 1'b1, 3'd2, 32'h00, "t4_mode");
    expect_c(32'h10, 1'b1); drive(8'h10, 1'b0, 1'b0, 3'd0, 32'h0, "t4_intr");
    expect_c(32'h10, 1'b0); drive(8'h10, 1'b1, 1'b0, 3'd3, 32'h0, "t4_ack_isr");
    expect_c(32'h10, 1'b0); drive(8'h10, 1'b0, 1'b0, 3'd3, 32'h0, "t4_hold");
    expect_c(32'h10, 1'b0); drive(8'h10, 1'b0, 1'b0, 3'd3, 32'h0, "t4_noreq");
    expect_c(32'h0, 1'b1); drive(8'h10, 1'b0, 1'b1, 3'd5, 32'h0, "t4_eoi_intr");
    expect_c(32'h0, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd0, 32'h0, "t4_drop");
    // Masked while requesting, then spurious acknowledge.
    drive(8'h00, 1'b0, 1'b1, 3'd2, 32'h20, "t5_mode");
    drive(8'h00, 1'b0, 1'b1, 3'd1, 32'h20, "t5_mask");
    expect_c(32'h20, 1'b0); drive(8'h20, 1'b0, 1'b0, 3'd0, 32'h0, "t5_pend");
    expect_c(32'h20, 1'b1); drive(8'h20, 1'b0, 1'b0, 3'd0, 32'h0, "t5_intr");
    expect_c(32'h0, 1'b0); drive(8'h20, 1'b0, 1'b1, 3'd1, 32'h0, "t5_unmask");
    expect_c(32'h4000_0000, 1'b0); drive(8'h20, 1'b1, 1'b0, 3'd4, 32'h0, "t5_spur");
    expect_c(32'h0, 1'b0); drive(8'h20, 1'b0, 1'b0, 3'd3, 32'h0, "t5_isr0");
    expect_c(32'h0, 1'b0); drive(8'h20, 1'b0, 1'b1, 3'd4, 32'h4000_0000, "t5_spur_clr");
    // Software interrupt, set-beats-clear, asynchronous reset mid-request.
    drive(8'h00, 1'b0, 1'b1, 3'd0, 32'h20, "t6_w1c");
    drive(8'h00, 1'b0, 1'b1, 3'd2, 32'h40, "t6_mode");
    drive(8'h00, 1'b0, 1'b1, 3'd1, 32'h40, "t6_mask");
    expect_c(32'h0, 1'b1); drive(8'h00, 1'b0, 1'b1, 3'd6, 32'h40, "t6_swi_intr");
    expect_c(32'h40, 1'b1); drive(8'h40, 1'b0, 1'b1, 3'd0, 32'h40, "t6_set_wins");
    src = '0; we = 1'b0; addr = 3'd1;
    #1 clrn = 1'b0;
    #1;
    direct_chk("t6_rst_intr", {31'd0, intr}, 32'h0);
    direct_chk("t6_rst_mask", rdata, 32'h0);
    expect_c(32'h0, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd0, 32'h0, "t6_rst_pend");
    expect_c(32'h0, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd2, 32'h0, "t6_rst_mode");
    expect_c(32'h0, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd3, 32'h0, "t6_rst_isr");
    expect_c(32'h0, 1'b0); drive(8'h00, 1'b0, 1'b0, 3'd4, 32'h0, "t6_rst_vec");
    clrn = 1'b1;
    // Random traffic against the model.
    s = '0;
    for (int k = 0; k < 3000; k++) begin
      s  = s ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      ia = (m_st == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      w  = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      drive(s, ia, w, a, d, "rand");
    end
    drive('0, 1'b0, 1'b0, 3'd0, 32'h0, "final");
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
